// File: rtl/capture_bank_controller.sv
// Capture/readout sequencer for a bank-interleaved sample store: fills every
// bank in bank-major order, then streams all stored words out on valid/ready.
module capture_bank_controller #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int NUM_BANKS = 3,
    parameter int BANK_W    = 6
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [DATA_W-1:0]             signal_in,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W-1:0]             mem_data,
    output logic [NUM_BANKS-1:0]          mem_wren,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_q,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          rd_last,
    output logic                          busy,
    output logic                          done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CAPTURE = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RD_HOLD = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
    logic [DATA_W-1:0] bank_q;
    logic              addr_end;
    logic              at_last;

    assign addr_end = (addr == {ADDR_W{1'b1}});
    assign at_last  = addr_end && (bank == LAST_BANK);

    assign mem_address = addr;
    assign mem_data    = signal_in;
    assign busy        = (state != IDLE);
    // An abort landing on the FINISH cycle still cancels the completion pulse.
    assign done        = (state == FINISH) && !abort;

    always_comb begin
        bank_q   = '0;
        mem_wren = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank == BANK_W'(k))
                bank_q = mem_q[k*DATA_W +: DATA_W];
            mem_wren[k] = (state == CAPTURE) && (bank == BANK_W'(k)) && !abort;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            bank     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (abort && state != IDLE) begin
            state    <= IDLE;
            addr     <= '0;
            bank     <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= CAPTURE;
                        addr  <= '0;
                        bank  <= '0;
                    end
                end
                CAPTURE: begin
                    addr <= addr + 1'b1;
                    if (addr_end)
                        bank <= bank + 1'b1;
                    if (at_last) begin
                        state <= RD_ADDR;
                        addr  <= '0;
                        bank  <= '0;
                    end
                end
                RD_ADDR: state <= RD_WAIT;
                // Address was presented last cycle, so the selected bank's q is valid now.
                RD_WAIT: begin
                    rd_data  <= bank_q;
                    rd_valid <= 1'b1;
                    rd_last  <= at_last;
                    state    <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (rd_last) begin
                            state <= FINISH;
                        end else begin
                            addr  <= addr + 1'b1;
                            if (addr_end)
                                bank <= bank + 1'b1;
                            state <= RD_ADDR;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_bank_controller.sv
// Directed bench for capture_bank_controller with ADDR_W=4, NUM_BANKS=3 and
// behavioural one-cycle-latency RAM banks.
module tb_capture_bank_controller;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int NB     = 3;
    localparam int DEPTH  = 16;
    localparam int TOTAL  = NB * DEPTH;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              start, abort, rd_ready;
    logic [DATA_W-1:0] signal_in;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [NB-1:0]     mem_wren;
    logic [NB*DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_last, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    capture_bank_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NB), .BANK_W(6)
    ) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
        .signal_in(signal_in), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] ram [NB][DEPTH];
    logic [DATA_W-1:0] q   [NB];

    always @(posedge clock) begin
        for (int k = 0; k < NB; k++) begin
            if (mem_wren[k]) ram[k][mem_address] <= mem_data;
            q[k] <= ram[k][mem_address];
        end
    end
    assign mem_q = {q[2], q[1], q[0]};

    always @(negedge clock) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge; checks every write-side cycle of the capture.
    task automatic do_capture(input int abort_at, input bit pulse_start);
        chk("idle_busy", busy, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int n = 0; n < TOTAL; n++) begin
            signal_in = DATA_W'(16'h100 + n);
            abort     = (n == abort_at);
            start     = pulse_start && (n == 10);
            #1;
            if (n == abort_at) begin
                chk("abort_wren", mem_wren, 0);
                chk("abort_addr", mem_address, 4);
                @(negedge clock);
                abort = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_wren_after", mem_wren, 0);
                return;
            end
            chk($sformatf("cap_wren_%0d", n), mem_wren, 32'(1 << (n / DEPTH)));
            chk($sformatf("cap_addr_%0d", n), mem_address, n % DEPTH);
            @(negedge clock);
        end
        start = 1'b0;
        #1;
        chk("post_cap_wren", mem_wren, 0);
        chk("post_cap_busy", busy, 1);
    endtask

    // Starts in RD_ADDR; duty is the percentage of cycles rd_ready is high.
    task automatic do_readout(input int duty, input int done_exp);
        int idx = 0, cyc = 0, last_cyc = 0;
        bit held = 0;
        logic [DATA_W-1:0] hd;
        logic hl;
        bit nr;
        while (idx < TOTAL && cyc < 2000) begin
            if (held) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_data", rd_data, hd);
                chk("hold_last", rd_last, hl);
            end
            chk("rd_wren0", mem_wren, 0);
            nr = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            start    = rd_valid && (idx == 5);
            rd_ready = nr;
            if (rd_valid) begin
                if (nr) begin
                    chk($sformatf("rd_data_%0d", idx), rd_data, 32'(16'h100 + idx));
                    chk($sformatf("rd_last_%0d", idx), rd_last, (idx == TOTAL - 1));
                    if (duty >= 100 && idx > 0) chk("rd_spacing", cyc - last_cyc, 3);
                    last_cyc = cyc;
                    idx++;
                    held = 0;
                end else begin
                    held = 1;
                    hd = rd_data;
                    hl = rd_last;
                end
            end
            @(negedge clock);
            cyc++;
        end
        chk("rd_count", idx, TOTAL);
        start = 1'b0;
        chk("finish_done", done, 1);
        chk("finish_busy", busy, 1);
        chk("finish_valid", rd_valid, 0);
        rd_ready = 1'b0;
        @(negedge clock);
        chk("idle_done", done, 0);
        chk("idle_busy_after", busy, 0);
        @(negedge clock);
        chk("done_count", done_cnt, done_exp);
    endtask

    initial begin
        int w;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b0; signal_in = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clock);

        // full capture with a stray start, then full-rate readout
        do_capture(-1, 1'b1);
        do_readout(100, 1);

        // back-pressured readout with a stray start while holding
        do_capture(-1, 1'b0);
        do_readout(30, 2);

        // abort on capture cycle 20
        do_capture(20, 1'b0);
        repeat (5) begin
            @(negedge clock);
            chk("abort_idle_wren", mem_wren, 0);
        end
        chk("abort_no_done", done_cnt, 2);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        chk("sa_busy0", busy, 0);
        start = 1'b0; abort = 1'b0;
        @(negedge clock);
        chk("sa_busy1", busy, 0);

        // asynchronous reset while a readback word is pending
        do_capture(-1, 1'b0);
        rd_ready = 1'b0;
        w = 0;
        while (!rd_valid && w < 10) begin
            @(negedge clock);
            w++;
        end
        chk("rst_wait_valid", rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_wren", mem_wren, 0);
        chk("arst_done", done, 0);
        chk("arst_busy", busy, 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        do_capture(-1, 1'b0);
        do_readout(100, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
